// File: rtl/mem_5_in_pkg.sv
// -----------------------------------------------------------------------------
// mem_5_in_pkg
// Shared definitions for the DNN memory group writers.
//   WORD_WIDTH_DEF / ADDR_WIDTH_DEF : default data-word and address widths
//   GROUP_SIZE                      : number of words carried by one input group
//   IDX_FIRST / IDX_LAST            : first and last values of the word index
//   state_e                         : IDLE / WRITE state encoding
// -----------------------------------------------------------------------------
package mem_5_in_pkg;

  localparam int WORD_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int GROUP_SIZE     = 5;

  localparam logic [2:0] IDX_FIRST = 3'd0;
  localparam logic [2:0] IDX_LAST  = 3'd4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

endpackage : mem_5_in_pkg

// File: rtl/mem_5_in.sv
// -----------------------------------------------------------------------------
// mem_5_in
// Accepts a group of five words in one handshake and streams them, one word per
// cycle, into an external memory at consecutive (wrapping) addresses starting
// at an internal write pointer. The pointer is loaded from base_addr by start
// while idle and advances by five after every group.
//
// Ports
//   clk                  : clock, rising edge
//   rst                  : asynchronous, active-high reset
//   start                : load write pointer from base_addr (IDLE only)
//   base_addr            : start address for the next sequence of groups
//   in_valid / in_ready  : group handshake
//   data_in_0..data_in_4 : group words; word k goes to pointer+k
//   wr_en                : memory write strobe (registered)
//   wr_addr              : memory write address (registered)
//   wr_data              : memory write data (registered)
//   wr_last              : marks the fifth word of a group (registered)
//   busy                 : high while in WRITE (registered)
// -----------------------------------------------------------------------------
module mem_5_in
  import mem_5_in_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] data_in_0,
  input  logic [WORD_WIDTH-1:0] data_in_1,
  input  logic [WORD_WIDTH-1:0] data_in_2,
  input  logic [WORD_WIDTH-1:0] data_in_3,
  input  logic [WORD_WIDTH-1:0] data_in_4,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  wr_last,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] GROUP_STEP = ADDR_WIDTH'(GROUP_SIZE);

  // State, index and pointer
  state_e                  state_r;
  logic [2:0]              idx_r;
  logic [ADDR_WIDTH-1:0]   ptr_r;
  logic [WORD_WIDTH-1:0]   hold_r [GROUP_SIZE];

  // Registered memory-side outputs
  logic                    wr_en_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic [WORD_WIDTH-1:0]   wr_data_r;
  logic                    wr_last_r;
  logic                    busy_r;

  // Combinational helpers
  logic                    in_ready_s;
  logic                    accept_s;
  logic [2:0]              next_idx_s;
  logic [ADDR_WIDTH-1:0]   grp_ptr_s;
  logic [ADDR_WIDTH-1:0]   next_addr_s;
  logic [WORD_WIDTH-1:0]   next_word_s;

  // Handshake, pointer selection and next-word lookup
  always_comb begin
    in_ready_s  = 1'b0;
    accept_s    = 1'b0;
    next_idx_s  = 3'd0;
    grp_ptr_s   = ptr_r;
    next_addr_s = ptr_r;
    next_word_s = hold_r[0];

    // Ready while idle, and on the last word so groups chain without a bubble.
    in_ready_s = (state_r == ST_IDLE) || (idx_r == IDX_LAST);
    accept_s   = in_valid && in_ready_s;
    next_idx_s = idx_r + 3'd1;

    // Pointer for a group accepted this cycle. In IDLE, start takes effect
    // immediately so a same-cycle group lands at base_addr. In WRITE the only
    // acceptance point is the last word, where the pointer steps past the
    // group being finished; start is ignored there.
    case (state_r)
      ST_IDLE:  grp_ptr_s = start ? base_addr : ptr_r;
      ST_WRITE: grp_ptr_s = ptr_r + GROUP_STEP;
      default:  grp_ptr_s = ptr_r;
    endcase

    next_addr_s = ptr_r + ADDR_WIDTH'(next_idx_s);

    case (next_idx_s)
      3'd1:    next_word_s = hold_r[1];
      3'd2:    next_word_s = hold_r[2];
      3'd3:    next_word_s = hold_r[3];
      3'd4:    next_word_s = hold_r[4];
      default: next_word_s = hold_r[0];
    endcase
  end

  // Group writer FSM with registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      idx_r     <= IDX_FIRST;
      ptr_r     <= '0;
      for (int k = 0; k < GROUP_SIZE; k++) begin
        hold_r[k] <= '0;
      end
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      wr_last_r <= 1'b0;
      busy_r    <= 1'b0;
    end else if (accept_s) begin
      // New group: capture all five words and present word 0 next cycle.
      state_r   <= ST_WRITE;
      idx_r     <= IDX_FIRST;
      ptr_r     <= grp_ptr_s;
      hold_r[0] <= data_in_0;
      hold_r[1] <= data_in_1;
      hold_r[2] <= data_in_2;
      hold_r[3] <= data_in_3;
      hold_r[4] <= data_in_4;
      wr_en_r   <= 1'b1;
      wr_addr_r <= grp_ptr_s;
      wr_data_r <= data_in_0;
      wr_last_r <= 1'b0;
      busy_r    <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // start alone just reloads the pointer; wr_addr/wr_data keep their values.
          ptr_r     <= grp_ptr_s;
          wr_en_r   <= 1'b0;
          wr_last_r <= 1'b0;
          busy_r    <= 1'b0;
        end
        ST_WRITE: begin
          if (idx_r == IDX_LAST) begin
            // Group finished with no follow-on group waiting.
            state_r   <= ST_IDLE;
            idx_r     <= IDX_FIRST;
            ptr_r     <= grp_ptr_s;
            wr_en_r   <= 1'b0;
            wr_last_r <= 1'b0;
            busy_r    <= 1'b0;
          end else begin
            idx_r     <= next_idx_s;
            wr_en_r   <= 1'b1;
            wr_addr_r <= next_addr_s;
            wr_data_r <= next_word_s;
            wr_last_r <= (next_idx_s == IDX_LAST);
            busy_r    <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          idx_r     <= IDX_FIRST;
          wr_en_r   <= 1'b0;
          wr_last_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_s;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign wr_last  = wr_last_r;
  assign busy     = busy_r;

endmodule : mem_5_in

// File: tb/tb_mem_5_in.sv
// -----------------------------------------------------------------------------
// tb_mem_5_in
// Directed bench for mem_5_in with an external memory model. Outputs are
// sampled 1 time unit after each rising edge, where inputs are also driven.
// -----------------------------------------------------------------------------
module tb_mem_5_in;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] din [5];
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_last;
  logic        busy;

  int vectors    = 0;
  int miscompares = 0;

  // External memory model
  logic [15:0] mem [16];
  logic        mem_clear = 1'b0;

  // Packed view: {wr_en, wr_last, busy, in_ready, wr_addr, wr_data}
  wire [23:0] snap = {wr_en, wr_last, busy, in_ready, wr_addr, wr_data};

  mem_5_in #(.WORD_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in_0 (din[0]),
    .data_in_1 (din[1]),
    .data_in_2 (din[2]),
    .data_in_3 (din[3]),
    .data_in_4 (din[4]),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; base_addr = 4'd0;
    for (int k = 0; k < 5; k++) din[k] = 16'h0000;
    mem_clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_clear = 1'b0;
    vectors++;
    if (snap !== 24'h100000) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", snap, 24'h100000);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    logic [15:0] w [5];
    logic [23:0] exp_v;
    logic        lst;
    w[0] = 16'h0011; w[1] = 16'h0022; w[2] = 16'h0033; w[3] = 16'h0044; w[4] = 16'h0055;
    start = 1'b1; base_addr = 4'd2; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) din[k] = w[k];
    cycle();
    start = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      lst   = (k == 4);
      exp_v = {1'b1, lst, 1'b1, lst, 4'd2 + 4'(k), w[k]};
      vectors++;
      if (snap !== exp_v) begin
        miscompares++;
        $display("FAIL single_word%0d: got %h want %h", k, snap, exp_v);
      end
      if (k < 4) cycle();
    end
    cycle();
    vectors++;
    if (snap !== {4'b0001, 4'd6, 16'h0055}) begin
      miscompares++;
      $display("FAIL single_idle_hold: got %h want %h", snap, {4'b0001, 4'd6, 16'h0055});
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_v;
    logic        lst;
    logic [15:0] wd;
    start = 1'b1; base_addr = 4'd0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) din[k] = 16'hA000 + 16'(k);
    cycle();
    start = 1'b0;
    for (int k = 0; k < 5; k++) din[k] = 16'hB000 + 16'(k);
    for (int i = 0; i < 10; i++) begin
      lst   = ((i % 5) == 4);
      wd    = (i < 5) ? (16'hA000 + 16'(i)) : (16'hB000 + 16'(i - 5));
      exp_v = {1'b1, lst, 1'b1, lst, 4'(i), wd};
      vectors++;
      if (snap !== exp_v) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: got %h want %h", i, snap, exp_v);
      end
      if (i == 5) in_valid = 1'b0;
      if (i < 9) cycle();
    end
    cycle();
    vectors++;
    if ({wr_en, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_end: got %b want 00", {wr_en, busy});
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_a [5];
    exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0; exp_a[3] = 4'd1; exp_a[4] = 4'd2;
    start = 1'b1; base_addr = 4'd14; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) din[k] = 16'hC000 + 16'(k);
    cycle();
    start = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, exp_a[k], 16'hC000 + 16'(k)}) begin
        miscompares++;
        $display("FAIL wrap_word%0d: got %b/%0d/%h want 1/%0d/%h", k, wr_en, wr_addr, wr_data,
                 exp_a[k], 16'hC000 + 16'(k));
      end
      cycle();
    end
    // Pointer should now be 3: a group without start continues there.
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) din[k] = 16'hD000 + 16'(k);
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd3 + 4'(k), 16'hD000 + 16'(k)}) begin
        miscompares++;
        $display("FAIL wrap_next%0d: got %0d/%h want %0d/%h", k, wr_addr, wr_data,
                 4'd3 + 4'(k), 16'hD000 + 16'(k));
      end
      cycle();
    end
  endtask

  task automatic test_start_ignored();
    start = 1'b1; base_addr = 4'd0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) din[k] = 16'hE000 + 16'(k);
    cycle();
    start = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        start = 1'b1; base_addr = 4'd9;
      end
      cycle();
    end
    // Now idle; start was held through the rest of the group, including idx 4.
    start = 1'b0; base_addr = 4'd0;
    vectors++;
    if (wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL start_ign_idle: got wr_en=%b want 0", wr_en);
    end
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) din[k] = 16'hF000 + 16'(k);
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd5 + 4'(k), 16'hF000 + 16'(k)}) begin
        miscompares++;
        $display("FAIL start_ign_word%0d: got %0d/%h want %0d/%h", k, wr_addr, wr_data,
                 4'd5 + 4'(k), 16'hF000 + 16'(k));
      end
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; base_addr = 4'd0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) din[k] = 16'h0E00 + 16'(k);
    cycle();
    start = 1'b0; in_valid = 1'b0;
    cycle();
    cycle();
    vectors++;
    if ({wr_en, wr_addr} !== {1'b1, 4'd2}) begin
      miscompares++;
      $display("FAIL rstmid_at_idx2: got %b/%0d want 1/2", wr_en, wr_addr);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (snap !== 24'h100000) begin
      miscompares++;
      $display("FAIL rstmid_immediate: got %h want %h", snap, 24'h100000);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_ready: got %b want 1", in_ready);
    end
    start = 1'b1; base_addr = 4'd0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) din[k] = 16'h0D00 + 16'(k);
    cycle();
    start = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'(k), 16'h0D00 + 16'(k)}) begin
        miscompares++;
        $display("FAIL rstmid_word%0d: got %b/%0d/%h want 1/%0d/%h", k, wr_en, wr_addr, wr_data,
                 k, 16'h0D00 + 16'(k));
      end
      cycle();
    end
    cycle();
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (mem[k] !== 16'h0D00 + 16'(k)) begin
        miscompares++;
        $display("FAIL rstmid_mem%0d: got %h want %h", k, mem[k], 16'h0D00 + 16'(k));
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_mem [16];
    logic [3:0]  mptr;
    logic        accepted;
    mptr = 4'd0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0000;
    mem_clear = 1'b1;
    cycle();
    mem_clear = 1'b0;
    for (int g = 0; g < 50; g++) begin
      for (int k = 0; k < 5; k++) din[k] = 16'($urandom);
      in_valid = 1'b1;
      if (g == 0 || $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        base_addr = 4'($urandom_range(0, 15));
      end
      accepted = 1'b0;
      for (int t = 0; t < 12 && !accepted; t++) begin
        if (start && !busy) mptr = base_addr;
        if (in_ready) begin
          for (int k = 0; k < 5; k++) exp_mem[mptr + 4'(k)] = din[k];
          mptr = mptr + 4'd5;
          accepted = 1'b1;
        end
        cycle();
      end
      start = 1'b0; in_valid = 1'b0;
      vectors++;
      if (accepted !== 1'b1) begin
        miscompares++;
        $display("FAIL rand_accept_g%0d: got no acceptance within 12 cycles, want accepted", g);
      end
      repeat ($urandom_range(0, 3)) cycle();
    end
    repeat (8) cycle();
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (mem[i] !== exp_mem[i]) begin
        miscompares++;
        $display("FAIL rand_dump_addr%0d: got %h want %h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mem_5_in
